picture_grid_logic: RTL and testbench
=====================================

Name: picture_grid_logic

Overview:
- Successor to the single-picture cover logic. Controls a parametrised ROWS x COLS grid of picture tiles; each tile is independently covered or revealed by mouse clicks.
- Per-pixel stage: chooses, registered, between picture RGB and cover RGB for the pixel currently being drawn.
- Sits in the draw_image chain, after the picture and cover generators and before the mouse overlay.
- Adds behaviour absent in the single-tile version: a limit on simultaneously open tiles and timed automatic re-cover.

Parameters:
- COLS, 4, tile columns (1..8)
- ROWS, 2, tile rows (1..8)
- X0, 64, x of left edge of tile (0,0)
- Y0, 64, y of top edge of tile (0,0)
- TILE_W, 128, tile width in pixels
- TILE_H, 128, tile height in pixels
- GAP, 16, pixel gap between adjacent tiles (both axes)
- MAX_OPEN, 2, max tiles simultaneously revealed (1..ROWS*COLS)
- HOLD_CYCLES, 65_000_000, clk cycles open tiles stay visible once MAX_OPEN is reached (>=1)

Ports:
- clk  in  1  pixel/system clock; single clock domain
- rst  in  1  synchronous reset, active-high
- MouseLeft  in  1  left button level, already synchronised to clk
- xpos  in  12  mouse x
- ypos  in  12  mouse y
- hcount  in  11  current pixel x
- vcount  in  11  current pixel y
- rgb_in1  in  12  picture colour for current pixel
- rgb_in2  in  12  cover colour for current pixel
- rgb_out  out  12  selected colour, 1-cycle latency
- open_mask  out  ROWS*COLS  bit i = tile i revealed (i = row*COLS+col)
- hold_active  out  1  auto-cover timer running

Behaviour:
- Reset, synchronous active-high: rgb_out=0, open_mask=0 (all covered), hold_active=0, click FSM in IDLE, timer=0.
- Hit test is combinational, shared by mouse and pixel paths. A point is in tile (r,c) when:
  - X0+c*(TILE_W+GAP) <= x <= X0+c*(TILE_W+GAP)+TILE_W-1, and
  - the same rule holds for y with ROWS/TILE_H.
  - Points in gaps or outside the grid give no hit.
  - Comparisons are 12-bit unsigned; hcount/vcount are zero-extended.
- Click FSM states: IDLE, PRESSED, RELEASE.
  - IDLE: MouseLeft=1 and the mouse is in tile k -> latch k, go to PRESSED. MouseLeft=1 outside every tile -> go to RELEASE (press consumed, no action).
  - PRESSED: wait for MouseLeft=0. On that cycle apply the action to latched k, even if the cursor has left the tile, then go to IDLE.
  - RELEASE: wait for MouseLeft=0, then go to IDLE.
  - At most one action per press/release pair. A held button never repeats.
- Action on tile k, applied on the release cycle; open_mask updates on the next edge:
  - k open -> close k.
  - k covered and popcount(open_mask) < MAX_OPEN -> open k.
  - k covered and count == MAX_OPEN -> ignored.
  - Any action while hold_active=1 -> ignored. The FSM still cycles normally.
- Auto-cover:
  - When popcount(open_mask) becomes MAX_OPEN, hold_active=1 from the next cycle and the timer loads 0.
  - Timer counts each cycle. At count HOLD_CYCLES-1, open_mask<=0 and hold_active<=0 on that edge.
  - Timer width is $clog2(HOLD_CYCLES+1).
  - If count drops below MAX_OPEN it cannot, since clicks are blocked while hold_active=1.
- Pixel path, registered, 1 cycle:
  - (hcount,vcount) in tile j and open_mask[j]=1 -> rgb_out<=rgb_in1.
  - In tile j and covered -> rgb_in2.
  - Outside all tiles -> rgb_in1.
  - Uses open_mask as currently registered. A mid-frame change takes effect at the next pixel.
- Reset mid-hold or mid-press: everything returns to reset values. A button still held after reset is treated as a fresh press.
- MAX_OPEN=ROWS*COLS: the hold triggers only when every tile is open.

Decomposition:
- vga_pkg gains grid defaults: GRID_COLS, GRID_ROWS, GRID_X0, GRID_Y0, TILE_W, TILE_H, TILE_GAP. Module parameters default to these.
- Click FSM enum typedef click_state_t lives in the module, not the package.
- One sub-module is natural: tile_hit (params as above; inputs x, y 12-bit; outputs hit 1-bit, idx $clog2(ROWS*COLS)-bit). It is instantiated twice: mouse path and pixel path.

Test Plan:
- Reset, then hcount=X0, vcount=Y0 with rgb_in1=12'hF00, rgb_in2=12'h0F0 -> rgb_out=12'h0F0 one cycle later; open_mask=0.
- Mouse at (X0+10,Y0+10), press 5 cycles, release -> open_mask=8'b0000_0001 after the release edge. Pixel in tile 0 -> 12'hF00. Press again -> 0.
- Press on tile 1, move cursor to a gap, release -> bit 1 set. Press in a gap, move to tile 2, release -> no change.
- MAX_OPEN=2, HOLD_CYCLES=20: open tiles 0 and 3 -> hold_active=1. A click on tile 5 during the hold is ignored. After exactly 20 cycles open_mask=0 and hold_active=0.
- Hold button 100 cycles on tile 0 -> single toggle only. Assert rst while PRESSED -> open_mask=0, no toggle on later release.
- Sweep hcount across the tile-0/tile-1 boundary: X0+TILE_W-1 is in tile 0, X0+TILE_W..+GAP-1 counts as outside (rgb_in1), X0+TILE_W+GAP is in tile 1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared display constants, including the default picture-grid geometry.
package vga_pkg;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 2;
  localparam int GRID_X0 = 64;
  localparam int GRID_Y0 = 64;
  localparam int TILE_W = 128;
  localparam int TILE_H = 128;
  localparam int TILE_GAP = 16;
endpackage

// File: rtl/picture_grid_logic_tile_hit.sv
// tile_hit: combinational test of which grid tile, if any, contains point (x,y).
module tile_hit
  import vga_pkg::*;
#(
  parameter int COLS = vga_pkg::GRID_COLS,
  parameter int ROWS = vga_pkg::GRID_ROWS,
  parameter int X0 = vga_pkg::GRID_X0,
  parameter int Y0 = vga_pkg::GRID_Y0,
  parameter int TILE_W = vga_pkg::TILE_W,
  parameter int TILE_H = vga_pkg::TILE_H,
  parameter int GAP = vga_pkg::TILE_GAP,
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic [11:0]   x,
  input  logic [11:0]   y,
  output logic          hit,
  output logic [IW-1:0] idx
);
  logic       hit_c, hit_r;
  logic [3:0] col, row;
  always_comb begin
    hit_c = 1'b0;
    hit_r = 1'b0;
    col = '0;
    row = '0;
    for (int c = 0; c < COLS; c++)
      if (int'(x) >= X0 + c * (TILE_W + GAP) && int'(x) < X0 + c * (TILE_W + GAP) + TILE_W) begin
        hit_c = 1'b1;
        col = 4'(c);
      end
    for (int r = 0; r < ROWS; r++)
      if (int'(y) >= Y0 + r * (TILE_H + GAP) && int'(y) < Y0 + r * (TILE_H + GAP) + TILE_H) begin
        hit_r = 1'b1;
        row = 4'(r);
      end
    hit = hit_c & hit_r;
    idx = IW'(int'(row) * COLS + int'(col));
  end
endmodule

// File: rtl/picture_grid_logic.sv
// picture_grid_logic: per-tile click reveal/cover of a picture grid with an open-tile
// limit, timed auto-cover and a registered picture/cover pixel mux.
module picture_grid_logic
  import vga_pkg::*;
#(
  parameter int COLS = vga_pkg::GRID_COLS,
  parameter int ROWS = vga_pkg::GRID_ROWS,
  parameter int X0 = vga_pkg::GRID_X0,
  parameter int Y0 = vga_pkg::GRID_Y0,
  parameter int TILE_W = vga_pkg::TILE_W,
  parameter int TILE_H = vga_pkg::TILE_H,
  parameter int GAP = vga_pkg::TILE_GAP,
  parameter int MAX_OPEN = 2,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MouseLeft,
  input  logic [11:0]          xpos,
  input  logic [11:0]          ypos,
  input  logic [10:0]          hcount,
  input  logic [10:0]          vcount,
  input  logic [11:0]          rgb_in1,
  input  logic [11:0]          rgb_in2,
  output logic [11:0]          rgb_out,
  output logic [ROWS*COLS-1:0] open_mask,
  output logic                 hold_active
);
  localparam int N = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PRESSED, RELEASE} click_state_t;
  click_state_t  state_q, state_d;
  logic [IW-1:0] k_q, k_d, m_idx, p_idx;
  logic [N-1:0]  open_q, open_d;
  logic          hold_q, hold_d, m_hit, p_hit;
  logic [TW-1:0] timer_q, timer_d;
  logic [11:0]   rgb_q, rgb_d;
  tile_hit #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .TILE_W(TILE_W), .TILE_H(TILE_H), .GAP(GAP))
    u_mouse_hit (.x(xpos), .y(ypos), .hit(m_hit), .idx(m_idx));
  tile_hit #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .TILE_W(TILE_W), .TILE_H(TILE_H), .GAP(GAP))
    u_pixel_hit (.x({1'b0, hcount}), .y({1'b0, vcount}), .hit(p_hit), .idx(p_idx));
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    open_d = open_q;
    hold_d = hold_q;
    timer_d = timer_q;
    if (state_q == IDLE && MouseLeft) begin
      state_d = m_hit ? PRESSED : RELEASE;
      k_d = m_idx;
    end else if (state_q != IDLE && !MouseLeft) begin
      state_d = IDLE;
      if (state_q == PRESSED && !hold_q)
        open_d[k_q] = open_q[k_q] ? 1'b0 : ($countones(open_q) < MAX_OPEN);
    end
    // the timer only starts on the edge where the open count first reaches the limit
    if (hold_q) begin
      timer_d = timer_q + TW'(1);
      if (timer_q == TW'(HOLD_CYCLES - 1)) begin
        open_d = '0;
        hold_d = 1'b0;
      end
    end else if ($countones(open_d) == MAX_OPEN) begin
      hold_d = 1'b1;
      timer_d = '0;
    end
    rgb_d = (p_hit && !open_q[p_idx]) ? rgb_in2 : rgb_in1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      open_q <= '0;
      hold_q <= 1'b0;
      timer_q <= '0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      open_q <= open_d;
      hold_q <= hold_d;
      timer_q <= timer_d;
      rgb_q <= rgb_d;
    end
  end
  assign rgb_out = rgb_q;
  assign open_mask = open_q;
  assign hold_active = hold_q;
endmodule

// File: tb/tb_picture_grid_logic.sv
// tb_picture_grid_logic: directed checks of click toggling, open limit, auto-cover and pixel mux.
module tb_picture_grid_logic;
  logic        clk = 1'b0;
  logic        rst, MouseLeft;
  logic [11:0] xpos, ypos, rgb_in1, rgb_in2, rgb_out;
  logic [10:0] hcount, vcount;
  logic [7:0]  open_mask;
  logic        hold_active;
  int          checks = 0;
  int          errors = 0;
  picture_grid_logic #(.MAX_OPEN(2), .HOLD_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .MouseLeft(MouseLeft), .xpos(xpos), .ypos(ypos),
    .hcount(hcount), .vcount(vcount), .rgb_in1(rgb_in1), .rgb_in2(rgb_in2),
    .rgb_out(rgb_out), .open_mask(open_mask), .hold_active(hold_active)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic click(input int x, input int y, input int n, input int x2, input int y2);
    xpos = 12'(x);
    ypos = 12'(y);
    MouseLeft = 1'b1;
    step(n);
    xpos = 12'(x2);
    ypos = 12'(y2);
    MouseLeft = 1'b0;
    step(1);
  endtask
  initial begin
    rst = 1'b1;
    MouseLeft = 1'b0;
    xpos = '0;
    ypos = '0;
    hcount = 11'd64;
    vcount = 11'd64;
    rgb_in1 = 12'hF00;
    rgb_in2 = 12'h0F0;
    step(2);
    chk("reset_rgb", 32'(rgb_out), 32'h000);
    chk("reset_mask", 32'(open_mask), 32'h00);
    chk("reset_hold", 32'(hold_active), 32'h0);
    rst = 1'b0;
    step(1);
    chk("covered_tile0_rgb", 32'(rgb_out), 32'h0F0);
    click(74, 74, 5, 74, 74);
    chk("open_tile0", 32'(open_mask), 32'h01);
    step(1);
    chk("revealed_tile0_rgb", 32'(rgb_out), 32'hF00);
    click(74, 74, 5, 74, 74);
    chk("close_tile0", 32'(open_mask), 32'h00);
    click(218, 74, 3, 200, 74);
    chk("drag_off_tile1", 32'(open_mask), 32'h02);
    click(200, 74, 3, 362, 74);
    chk("gap_press_ignored", 32'(open_mask), 32'h02);
    click(218, 74, 2, 218, 74);
    chk("close_tile1", 32'(open_mask), 32'h00);
    click(74, 74, 2, 74, 74);
    chk("reopen_tile0", 32'(open_mask), 32'h01);
    click(506, 74, 2, 506, 74);
    chk("open_tile3_mask", 32'(open_mask), 32'h09);
    chk("hold_starts", 32'(hold_active), 32'h1);
    click(218, 218, 2, 218, 218);
    chk("tile5_blocked", 32'(open_mask), 32'h09);
    step(16);
    chk("hold_cycle19_active", 32'(hold_active), 32'h1);
    chk("hold_cycle19_mask", 32'(open_mask), 32'h09);
    step(1);
    chk("autocover_mask", 32'(open_mask), 32'h00);
    chk("autocover_hold", 32'(hold_active), 32'h0);
    xpos = 12'd74;
    ypos = 12'd74;
    MouseLeft = 1'b1;
    step(100);
    chk("held_no_action", 32'(open_mask), 32'h00);
    MouseLeft = 1'b0;
    step(1);
    chk("held_single_toggle", 32'(open_mask), 32'h01);
    step(5);
    chk("no_repeat", 32'(open_mask), 32'h01);
    MouseLeft = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst_mid_press", 32'(open_mask), 32'h00);
    rst = 1'b0;
    MouseLeft = 1'b0;
    step(2);
    chk("no_toggle_after_rst", 32'(open_mask), 32'h00);
    hcount = 11'd191;
    step(1);
    chk("x191_tile0", 32'(rgb_out), 32'h0F0);
    hcount = 11'd192;
    step(1);
    chk("x192_gap", 32'(rgb_out), 32'hF00);
    hcount = 11'd207;
    step(1);
    chk("x207_gap", 32'(rgb_out), 32'hF00);
    hcount = 11'd208;
    step(1);
    chk("x208_tile1", 32'(rgb_out), 32'h0F0);
    vcount = 11'd63;
    step(1);
    chk("y63_outside", 32'(rgb_out), 32'hF00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
